// File: rtl/wb_exc_commit_pkg.sv
// Shared defines for the WB commit stage and the CSR file: exception codes,
// exception flag bundle and the commit FSM state encoding.
package wb_exc_commit_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    localparam logic [0:0] STATE_RUN      = 1'b0;
    localparam logic [0:0] STATE_REDIRECT = 1'b1;

    typedef struct packed {
        logic adef;
        logic ine;
        logic sys;
        logic brk;
        logic ale;
    } exc_flags_t;

endpackage

// File: rtl/wb_exc_commit_if.sv
// MEM->WB handshake bundle: master is the MEM stage, slave is the WB commit stage.
interface wb_exc_commit_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_vaddr;
    logic        in_ex_adef;
    logic        in_ex_ine;
    logic        in_ex_sys;
    logic        in_ex_brk;
    logic        in_ex_ale;
    logic        in_ertn;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic [31:0] in_rf_wdata;

    modport master (
        output in_valid, in_pc, in_vaddr,
        output in_ex_adef, in_ex_ine, in_ex_sys, in_ex_brk, in_ex_ale, in_ertn,
        output in_rf_we, in_rf_waddr, in_rf_wdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_vaddr,
        input  in_ex_adef, in_ex_ine, in_ex_sys, in_ex_brk, in_ex_ale, in_ertn,
        input  in_rf_we, in_rf_waddr, in_rf_wdata,
        output in_ready
    );

endinterface

// File: rtl/wb_exc_commit_prio.sv
// Exception priority encoder: INT > ADEF > INE > SYS > BRK > ALE.
module wb_exc_prio
    import wb_exc_commit_pkg::*;
(
    input  logic       int_pending,
    input  exc_flags_t flags,
    output logic       has_ex,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    always_comb begin
        has_ex   = 1'b1;
        ecode    = ECODE_INT;
        esubcode = ESUBCODE_NONE;
        if (int_pending)     ecode = ECODE_INT;
        else if (flags.adef) ecode = ECODE_ADEF;
        else if (flags.ine)  ecode = ECODE_INE;
        else if (flags.sys)  ecode = ECODE_SYS;
        else if (flags.brk)  ecode = ECODE_BRK;
        else if (flags.ale)  ecode = ECODE_ALE;
        else                 has_ex = 1'b0;
    end

endmodule

// File: rtl/wb_exc_commit.sv
// Write-back commit stage: exception/ertn commit, CSR record and IF redirect.
// Optional macro WB_EXC_PERF_CNT_EN adds the taken-exception counter ex_count.
module wb_exc_commit
    import wb_exc_commit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    wb_exc_commit_if.slave mem_wb,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        csr_crmd_ie,
    input  logic [12:0] csr_estat_is,
    input  logic [12:0] csr_ecfg_lie,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_csr_pc,
    output logic [31:0] wb_vaddr,
    output logic        flush_valid,
    input  logic        flush_ready,
    output logic [31:0] flush_target,
    output logic [31:0] ex_count
);

    logic [0:0]  state;
    logic        wb_valid;
    logic [31:0] wb_pc_q;
    logic [31:0] wb_vaddr_q;
    exc_flags_t  wb_flags;
    logic        wb_ertn;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;

    logic        accept;
    logic        commit;
    logic        int_pending;
    logic        has_ex;
    logic        redirect_now;

    assign mem_wb.in_ready = resetn;
    assign accept          = mem_wb.in_valid & mem_wb.in_ready;

    // Outputs are gated by resetn so nothing leaks out during the reset cycle.
    assign commit      = wb_valid & (state == STATE_RUN) & resetn;
    assign int_pending = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));

    wb_exc_prio u_prio (
        .int_pending (int_pending),
        .flags       (wb_flags),
        .has_ex      (has_ex),
        .ecode       (wb_ecode),
        .esubcode    (wb_esubcode)
    );

    assign wb_ex        = commit & has_ex;
    assign ertn_flush   = commit & wb_ertn & ~has_ex;
    assign redirect_now = wb_ex | ertn_flush;
    assign rf_we        = commit & wb_rf_we & ~has_ex;
    assign rf_waddr     = wb_rf_waddr;
    assign rf_wdata     = wb_rf_wdata;
    assign wb_csr_pc    = wb_pc_q;
    assign wb_vaddr     = wb_vaddr_q;
    assign flush_valid  = resetn & (state == STATE_REDIRECT);

    // Younger instructions arriving while a redirect is pending are dropped here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= accept & (state == STATE_RUN) & ~redirect_now;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wb_pc_q       <= mem_wb.in_pc;
            wb_vaddr_q    <= mem_wb.in_vaddr;
            wb_flags.adef <= mem_wb.in_ex_adef;
            wb_flags.ine  <= mem_wb.in_ex_ine;
            wb_flags.sys  <= mem_wb.in_ex_sys;
            wb_flags.brk  <= mem_wb.in_ex_brk;
            wb_flags.ale  <= mem_wb.in_ex_ale;
            wb_ertn       <= mem_wb.in_ertn;
            wb_rf_we      <= mem_wb.in_rf_we;
            wb_rf_waddr   <= mem_wb.in_rf_waddr;
            wb_rf_wdata   <= mem_wb.in_rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= STATE_RUN;
            flush_target <= '0;
        end else begin
            case (state)
                STATE_RUN: begin
                    if (redirect_now) begin
                        state        <= STATE_REDIRECT;
                        flush_target <= wb_ex ? ex_entry : ertn_entry;
                    end
                end
                STATE_REDIRECT: begin
                    if (flush_ready) state <= STATE_RUN;
                end
                default: state <= STATE_RUN;
            endcase
        end
    end

`ifdef WB_EXC_PERF_CNT_EN
    logic [31:0] ex_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn)    ex_cnt_q <= '0;
        else if (wb_ex) ex_cnt_q <= ex_cnt_q + 32'd1;
    end

    assign ex_count = ex_cnt_q;
`else
    assign ex_count = '0;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_wb_exc_commit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_crmd_ie;
    logic [12:0] csr_estat_is;
    logic [12:0] csr_ecfg_lie;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        wb_ex;
    logic        ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_csr_pc;
    logic [31:0] wb_vaddr;
    logic        flush_valid;
    logic        flush_ready;
    logic [31:0] flush_target;
    logic [31:0] ex_count;

    always #5 clk = ~clk;

    wb_exc_commit_if bus();

    wb_exc_commit dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_wb       (bus),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .csr_crmd_ie  (csr_crmd_ie),
        .csr_estat_is (csr_estat_is),
        .csr_ecfg_lie (csr_ecfg_lie),
        .ex_entry     (ex_entry),
        .ertn_entry   (ertn_entry),
        .wb_ex        (wb_ex),
        .ertn_flush   (ertn_flush),
        .wb_ecode     (wb_ecode),
        .wb_esubcode  (wb_esubcode),
        .wb_csr_pc    (wb_csr_pc),
        .wb_vaddr     (wb_vaddr),
        .flush_valid  (flush_valid),
        .flush_ready  (flush_ready),
        .flush_target (flush_target),
        .ex_count     (ex_count)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Reference model: at most one pending instruction plus a redirect flag.
    bit          m_pv, m_redir, m_ertn, m_rfwe;
    logic [4:0]  m_fl;   // {adef, ine, sys, brk, ale}
    logic [31:0] m_pc, m_va, m_wd, m_target, m_count;
    logic [4:0]  m_wa;
    logic [5:0]  code_tab [6] = '{6'h0, 6'h8, 6'hD, 6'hB, 6'hC, 6'h9};

    // Snapshot of the outputs seen in the most recent tick.
    logic        s_ex, s_ertn, s_rf, s_fv;
    logic [5:0]  s_ecode;
    logic [4:0]  s_wa;
    logic [31:0] s_pc, s_tgt, s_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, want, $time);
        end
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] va, input logic [4:0] fl,
                       input bit ertn, input bit we, input logic [4:0] wa, input logic [31:0] wd);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_vaddr    = va;
        {bus.in_ex_adef, bus.in_ex_ine, bus.in_ex_sys, bus.in_ex_brk, bus.in_ex_ale} = fl;
        bus.in_ertn     = ertn;
        bus.in_rf_we    = we;
        bus.in_rf_waddr = wa;
        bus.in_rf_wdata = wd;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Check the current cycle against the model, advance the model, move to the next cycle.
    task automatic tick();
        bit causes [6];
        bit has, commit, e_ex, e_ertn, e_rf, new_pv;
        logic [5:0] code;
        #1;
        causes = '{csr_crmd_ie && ((csr_estat_is & csr_ecfg_lie) != 13'd0),
                   m_fl[4], m_fl[3], m_fl[2], m_fl[1], m_fl[0]};
        has = 1'b0;
        code = 6'h0;
        for (int i = 0; i < 6; i++) begin
            if (causes[i] && !has) begin
                has = 1'b1;
                code = code_tab[i];
            end
        end
        commit = resetn && m_pv && !m_redir;
        e_ex   = commit && has;
        e_ertn = commit && m_ertn && !has;
        e_rf   = commit && m_rfwe && !has;

        check("in_ready", bus.in_ready, resetn);
        check("wb_ex", wb_ex, e_ex);
        check("ertn_flush", ertn_flush, e_ertn);
        check("rf_we", rf_we, e_rf);
        if (e_rf) begin
            check("rf_waddr", rf_waddr, m_wa);
            check("rf_wdata", rf_wdata, m_wd);
        end
        if (e_ex) begin
            check("wb_ecode", wb_ecode, code);
            check("wb_esubcode", wb_esubcode, 0);
            check("wb_csr_pc", wb_csr_pc, m_pc);
            check("wb_vaddr", wb_vaddr, m_va);
        end
        check("flush_valid", flush_valid, resetn && m_redir);
        if (resetn && m_redir) check("flush_target", flush_target, m_target);
        check("ex_count", ex_count, m_count);

        s_ex = wb_ex; s_ertn = ertn_flush; s_rf = rf_we; s_fv = flush_valid;
        s_ecode = wb_ecode; s_wa = rf_waddr; s_pc = wb_csr_pc; s_tgt = flush_target; s_cnt = ex_count;

        if (!resetn) begin
            m_pv = 1'b0; m_redir = 1'b0; m_target = 32'h0; m_count = 32'h0;
        end else begin
            new_pv = bus.in_valid && !m_redir && !e_ex && !e_ertn;
            if (m_redir && flush_ready) m_redir = 1'b0;
            else if (e_ex || e_ertn) begin
                m_redir  = 1'b1;
                m_target = e_ex ? ex_entry : ertn_entry;
            end
`ifdef WB_EXC_PERF_CNT_EN
            if (e_ex) m_count = m_count + 32'd1;
`endif
            if (new_pv) begin
                m_pc = bus.in_pc; m_va = bus.in_vaddr; m_ertn = bus.in_ertn;
                m_fl = {bus.in_ex_adef, bus.in_ex_ine, bus.in_ex_sys, bus.in_ex_brk, bus.in_ex_ale};
                m_rfwe = bus.in_rf_we; m_wa = bus.in_rf_waddr; m_wd = bus.in_rf_wdata;
            end
            m_pv = new_pv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic syscall_redirect(input logic [31:0] pc);
        put(pc, 32'h0, 5'b00100, 1'b0, 1'b1, 5'd7, 32'h77);
        tick();
        idle();
        tick();
        tick();
    endtask

    int unsigned ertn_seen, rf_seen, fv_seen;

    initial begin
        resetn = 1'b0; flush_ready = 1'b1;
        csr_crmd_ie = 1'b0; csr_estat_is = '0; csr_ecfg_lie = '0;
        ex_entry = 32'h1C008000; ertn_entry = 32'h1C000024;
        put(32'h0, 32'h0, 5'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        idle();
        m_pv = 1'b0; m_redir = 1'b0; m_target = '0; m_count = '0;
        m_fl = '0; m_ertn = 1'b0; m_rfwe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        resetn = 1'b1;
        tick();
        check("rst_flush_valid", s_fv, 0);
        check("rst_ex_count", s_cnt, 0);

        // Back-to-back ADDs commit on consecutive cycles.
        put(32'h1C000000, 32'h0, 5'b0, 1'b0, 1'b1, 5'd1, 32'h11);
        tick();
        put(32'h1C000004, 32'h0, 5'b0, 1'b0, 1'b1, 5'd2, 32'h22);
        tick();
        check("b2b_we1", s_rf, 1); check("b2b_wa1", s_wa, 1); check("b2b_ex1", s_ex, 0);
        idle();
        tick();
        check("b2b_we2", s_rf, 1); check("b2b_wa2", s_wa, 2); check("b2b_ex2", s_ex, 0);

        // SYSCALL redirect.
        put(32'h1C000010, 32'h0, 5'b00100, 1'b0, 1'b1, 5'd3, 32'h33);
        tick();
        idle();
        tick();
        check("sys_ex", s_ex, 1); check("sys_ecode", s_ecode, 6'hB);
        check("sys_pc", s_pc, 32'h1C000010); check("sys_rf", s_rf, 0);
        tick();
        check("sys_fv", s_fv, 1); check("sys_tgt", s_tgt, 32'h1C008000);
        tick();

        // INE outranks ALE.
        put(32'h1C000018, 32'h00000003, 5'b01001, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        check("ale_ine_code", s_ecode, 6'hD);
        tick();

        // Interrupt on an ordinary ADD.
        csr_crmd_ie = 1'b1; csr_estat_is = 13'h0800; csr_ecfg_lie = 13'h0800;
        put(32'h1C000020, 32'h0, 5'b0, 1'b0, 1'b1, 5'd4, 32'h44);
        tick();
        idle();
        tick();
        check("int_ex", s_ex, 1); check("int_code", s_ecode, 6'h0);
        check("int_pc", s_pc, 32'h1C000020); check("int_rf", s_rf, 0);
        csr_crmd_ie = 1'b0; csr_estat_is = '0; csr_ecfg_lie = '0;
        tick();

        // ERTN with flush_ready held low for 5 cycles; younger inputs must vanish.
        flush_ready = 1'b0;
        put(32'h1C000030, 32'h0, 5'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        ertn_seen = 0; rf_seen = 0; fv_seen = 0;
        for (int i = 0; i < 7; i++) begin
            put(32'h1C000034 + 4 * i, 32'h0, 5'b0, 1'b0, 1'b1, 5'd9, 32'h99);
            if (i == 6) flush_ready = 1'b1;
            tick();
            ertn_seen += s_ertn; rf_seen += s_rf; fv_seen += s_fv;
        end
        idle();
        tick();
        rf_seen += s_rf;
        check("ertn_pulses", ertn_seen, 1);
        check("ertn_fv_cycles", fv_seen, 6);
        check("ertn_young_rf", rf_seen, 0);
        check("ertn_after_fv", s_fv, 0);

        // Three SYSCALLs from a fresh reset, then reset in the middle of a redirect.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        syscall_redirect(32'h1C000100);
        syscall_redirect(32'h1C000104);
        syscall_redirect(32'h1C000108);
        tick();
`ifdef WB_EXC_PERF_CNT_EN
        check("cnt_three", s_cnt, 3);
`else
        check("cnt_tied", s_cnt, 0);
`endif
        flush_ready = 1'b0;
        put(32'h1C000200, 32'h0, 5'b00100, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        check("mid_redirect_fv", s_fv, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check("post_rst_fv", s_fv, 0);
        check("post_rst_cnt", s_cnt, 0);
        flush_ready = 1'b1;
        tick();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            resetn       = ($urandom_range(0, 59) != 0);
            flush_ready  = $urandom_range(0, 1);
            csr_crmd_ie  = ($urandom_range(0, 3) == 0);
            csr_estat_is = 13'($urandom & $urandom & $urandom);
            csr_ecfg_lie = 13'($urandom);
            ex_entry     = $urandom;
            ertn_entry   = $urandom;
            if ($urandom_range(0, 3) != 0)
                put($urandom, $urandom,
                    {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) == 0)},
                    ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                    5'($urandom), $urandom);
            else
                idle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_exc_commit.md
WB_EXC_COMMIT -- requirements
Module: wb_exc_commit

Interface
REQ-001 clk  in  1  core clock.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 in_valid/in_ready  in/out  1/1  MEM->WB handshake; in_ready=0 during reset, 1 otherwise.
REQ-004 in_pc, in_vaddr  in  32/32  instruction PC; load/store effective address.
REQ-005 in_ex_adef, in_ex_ine, in_ex_sys, in_ex_brk, in_ex_ale, in_ertn  in  1 each  exception/ertn flags from MEM.
REQ-006 in_rf_we, in_rf_waddr, in_rf_wdata  in  1/5/32  pending regfile write.
REQ-007 rf_we, rf_waddr, rf_wdata  out  1/5/32  committed regfile write.
REQ-008 csr_crmd_ie, csr_estat_is, csr_ecfg_lie  in  1/13/13  interrupt state from CSR file.
REQ-009 ex_entry, ertn_entry  in  32/32  targets from CSR file.
REQ-010 wb_ex, ertn_flush  out  1/1  one-cycle commit pulses to CSR file.
REQ-011 wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr  out  6/9/32/32  exception record to CSR file.
REQ-012 flush_valid/flush_ready, flush_target  out/in, out  1/1, 32  redirect handshake to IF.
REQ-013 ex_count  out  32  taken-exception counter (see Configuration).

Function
REQ-014 Accepted instruction (in_valid&in_ready) SHALL latch into one WB register with wb_valid=1; commit evaluates in the following cycle.
REQ-015 int_pending SHALL = csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie), sampled in commit cycle.
REQ-016 Priority SHALL be INT(0x0) > ADEF(0x8,esub 0) > INE(0xD) > SYS(0xB) > BRK(0xC) > ALE(0x9); esubcode 0 for all.
REQ-017 wb_ex SHALL pulse one cycle when wb_valid & state==RUN & (int_pending | any flag); wb_csr_pc=WB PC; wb_vaddr=WB vaddr.
REQ-018 ertn_flush SHALL pulse when wb_valid & in_ertn & no exception; exception suppresses ertn.
REQ-019 rf_we SHALL = wb_valid & WB rf_we & ~wb_ex & state==RUN.
REQ-020 FSM states RUN, REDIRECT; RUN->REDIRECT on wb_ex or ertn_flush; REDIRECT->RUN on flush_valid&flush_ready.
REQ-021 On transition, flush_target SHALL latch ex_entry (exception) or ertn_entry (ertn) as sampled in commit cycle.
REQ-022 flush_valid SHALL = (state==REDIRECT); flush_target stable while flush_valid&~flush_ready.
REQ-023 Instruction accepted in the commit cycle of wb_ex/ertn_flush or while REDIRECT SHALL be discarded (wb_valid=0 next cycle, no CSR/rf effect).
REQ-024 flush_ready held 0 indefinitely SHALL keep REDIRECT and discard all input; no second wb_ex.
REQ-025 With no exception, one instruction SHALL commit per cycle (back-to-back, zero bubbles).

Reset
REQ-026 Reset: state=RUN, wb_valid=0, wb_ex=0, ertn_flush=0, rf_we=0, flush_valid=0, flush_target=0, ex_count=0, in_ready=0.
REQ-027 Reset during REDIRECT SHALL abandon redirect; no flush_valid next cycle.

Configuration
REQ-028 Macro WB_EXC_PERF_CNT_EN defined: ex_count increments by 1 per wb_ex, wraps 0xFFFFFFFF->0; undefined: ex_count tied 0, no counter flops.

Structure
REQ-029 Ecode/esubcode constants and the FSM state encoding SHALL live in the shared defines package used by the CSR file.
REQ-030 Priority selection SHALL be sub-module wb_exc_prio (combinational: flags+int_pending -> has_ex, ecode, esubcode).

Verification
REQ-031 ADD r1 then ADD r2 back-to-back, no ex -> rf_we two consecutive cycles, wb_ex never 1.
REQ-032 SYSCALL at PC 0x1C000010, ex_entry 0x1C008000 -> wb_ex 1 cycle, ecode 0xB, wb_csr_pc 0x1C000010, flush_target 0x1C008000, rf_we 0.
REQ-033 ALE (vaddr 0x00000003) with INE also set -> ecode 0xD, not 0x9.
REQ-034 crmd_ie=1, estat_is[11]=1, ecfg_lie[11]=1 on ADD at 0x1C000020 -> ecode 0x0, ERA PC 0x1C000020, no rf write.
REQ-035 ERTN, ertn_entry 0x1C000024, flush_ready low 5 cycles -> ertn_flush 1 cycle, flush_valid 5+ cycles, younger inputs dropped.
REQ-036 With WB_EXC_PERF_CNT_EN, three SYSCALLs -> ex_count=3; resetn low mid-REDIRECT -> ex_count=0, flush_valid 0.
